bram_line_engine: RTL and testbench

Parametrised line-transfer engine between the backstabber control logic and a single-port BRAM, and the successor to the 128-bit write-only BRAM interface. On a trigger it writes or reads a line of up to `LINE_W/WORD_W` consecutive BRAM words starting at a base address. Read data is reassembled into a line register. The block handles a configurable BRAM read latency, address wrap-around and illegal-length requests.

---
 rtl/bram_line_engine.sv | 245 ++++++++++++++++++++++++
 tb/tb_bram_line_engine.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_line_engine.sv
// bram_line_engine
// ----------------
// Moves one line of up to NW = LINE_W/WORD_W consecutive words between a line
// register and a single-port BRAM. A trigger in IDLE latches the request. Writes
// stream one word per cycle. Reads issue one address per cycle, and the data
// returning RD_LAT cycles later is placed into the matching slot of o_rddata.
// A length of 0 or more than NW is rejected. The engine then raises o_end with
// o_err and does not touch the BRAM.
//
// Ports
//   S_AXI_ACLK     clock
//   S_AXI_ARESET   asynchronous active-high reset
//   i_trigger      start request, sampled only in IDLE
//   i_mode         0 = read, 1 = write (sampled with the trigger)
//   i_base_addr    byte address of word 0 (forced to word alignment)
//   i_num_words    number of words, legal 1..NW
//   i_wrdata       write line, word k at [k*WORD_W +: WORD_W]
//   o_rddata       assembled read line
//   o_busy         transfer in progress
//   o_end          one-cycle completion pulse
//   o_err          one-cycle illegal-length pulse, coincident with o_end
//   o_bram_*       BRAM port: enable, byte write enables, byte address, write data
//   i_bram_rddata  BRAM read data, valid RD_LAT cycles after o_bram_en

module bram_line_engine #(
  parameter int LINE_W = 512,
  parameter int WORD_W = 32,
  parameter int ADDR_W = 15,
  parameter int RD_LAT = 2,
  localparam int NW = LINE_W / WORD_W,
  localparam int CW = $clog2(NW) + 1,
  localparam int BS = WORD_W / 8
) (
  input  logic              S_AXI_ACLK,
  input  logic              S_AXI_ARESET,
  input  logic              i_trigger,
  input  logic              i_mode,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic [CW-1:0]     i_num_words,
  input  logic [LINE_W-1:0] i_wrdata,
  output logic [LINE_W-1:0] o_rddata,
  output logic              o_busy,
  output logic              o_end,
  output logic              o_err,
  output logic              o_bram_en,
  output logic [BS-1:0]     o_bram_we,
  output logic [ADDR_W-1:0] o_bram_addr,
  output logic [WORD_W-1:0] o_bram_wrdata,
  input  logic [WORD_W-1:0] i_bram_rddata
);

  localparam int IW = (NW > 1) ? $clog2(NW) : 1;
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(BS - 1));

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_RD_ISSUE,
    S_RD_DRAIN,
    S_DONE
  } state_e;

  state_e                   state_q, state_d;
  logic [CW-1:0]            cnt_q, cnt_d;          // requested word count
  logic [CW-1:0]            idx_q, idx_d;          // words issued so far
  logic [IW-1:0]            bus_idx_q, bus_idx_d;  // index of the word on the bus now
  logic [LINE_W-1:0]        line_q, line_d;        // latched write line

  // Read-return tracker: stage i holds the word issued i+1 cycles ago.
  logic [RD_LAT-1:0]          pv_q;
  logic [RD_LAT-1:0][IW-1:0]  pidx_q;

  logic                     en_q, en_d;
  logic [BS-1:0]            we_q, we_d;
  logic [ADDR_W-1:0]        addr_q, addr_d;
  logic [WORD_W-1:0]        wrdata_q, wrdata_d;
  logic                     busy_q, busy_d;
  logic                     end_q, end_d;
  logic                     err_q, err_d;
  logic [LINE_W-1:0]        rddata_q, rddata_d;

  logic                     pipe_early_busy;

  // Reads still in flight that have not reached the last tracker stage. Once
  // this is clear in RD_DRAIN, the final word lands on the coming edge.
  always_comb begin
    pipe_early_busy = 1'b0;
    for (int i = 0; i < RD_LAT - 1; i++) begin
      pipe_early_busy = pipe_early_busy | pv_q[i];
    end
  end

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can leave
    // it unassigned and infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    bus_idx_d = bus_idx_q;
    line_d    = line_q;
    en_d      = 1'b0;
    we_d      = '0;
    addr_d    = '0;
    wrdata_d  = '0;
    busy_d    = 1'b0;
    end_d     = 1'b0;
    err_d     = 1'b0;
    rddata_d  = rddata_q;

    if (pv_q[RD_LAT-1]) begin
      rddata_d[int'(pidx_q[RD_LAT-1]) * WORD_W +: WORD_W] = i_bram_rddata;
    end

    unique case (state_q)
      S_IDLE: begin
        if (i_trigger) begin
          cnt_d  = i_num_words;
          line_d = i_wrdata;
          if (i_num_words == '0 || i_num_words > CW'(NW)) begin
            state_d = S_DONE;
            end_d   = 1'b1;
            err_d   = 1'b1;
          end else begin
            // Word 0 goes out on the very next cycle, so it is taken straight
            // from the inputs rather than from the latched copies.
            en_d      = 1'b1;
            addr_d    = i_base_addr & ALIGN_MASK;
            idx_d     = CW'(1);
            bus_idx_d = '0;
            busy_d    = 1'b1;
            if (i_mode) begin
              state_d  = S_WRITE;
              we_d     = '1;
              wrdata_d = i_wrdata[WORD_W-1:0];
            end else begin
              state_d  = S_RD_ISSUE;
              rddata_d = '0;
            end
          end
        end
      end

      S_WRITE: begin
        if (idx_q == cnt_q) begin
          state_d = S_DONE;
          end_d   = 1'b1;
        end else begin
          en_d      = 1'b1;
          we_d      = '1;
          addr_d    = addr_q + ADDR_W'(BS);  // wraps modulo 2^ADDR_W
          wrdata_d  = line_q[int'(idx_q[IW-1:0]) * WORD_W +: WORD_W];
          bus_idx_d = idx_q[IW-1:0];
          idx_d     = idx_q + CW'(1);
          busy_d    = 1'b1;
        end
      end

      S_RD_ISSUE: begin
        busy_d = 1'b1;
        if (idx_q == cnt_q) begin
          state_d = S_RD_DRAIN;
        end else begin
          en_d      = 1'b1;
          addr_d    = addr_q + ADDR_W'(BS);
          bus_idx_d = idx_q[IW-1:0];
          idx_d     = idx_q + CW'(1);
        end
      end

      S_RD_DRAIN: begin
        if (pipe_early_busy) begin
          busy_d = 1'b1;
        end else begin
          state_d = S_DONE;
          end_d   = 1'b1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: sequential state is assigned only with non-blocking assignments, so
  // every register samples the pre-edge values.
  // NOTE: the line registers are reset as well. An aborted read must show
  // o_rddata as 0, and nothing in the block is left undefined after reset.
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      bus_idx_q <= '0;
      line_q    <= '0;
      pv_q      <= '0;
      pidx_q    <= '0;
      en_q      <= 1'b0;
      we_q      <= '0;
      addr_q    <= '0;
      wrdata_q  <= '0;
      busy_q    <= 1'b0;
      end_q     <= 1'b0;
      err_q     <= 1'b0;
      rddata_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      bus_idx_q <= bus_idx_d;
      line_q    <= line_d;
      en_q      <= en_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wrdata_q  <= wrdata_d;
      busy_q    <= busy_d;
      end_q     <= end_d;
      err_q     <= err_d;
      rddata_q  <= rddata_d;

      // A read is in flight from the cycle its address is on the bus. After
      // RD_LAT cycles its data is present and it reaches the last stage.
      pv_q[0]   <= en_q & ~|we_q;
      pidx_q[0] <= bus_idx_q;
      for (int i = 1; i < RD_LAT; i++) begin
        pv_q[i]   <= pv_q[i-1];
        pidx_q[i] <= pidx_q[i-1];
      end
    end
  end

  assign o_rddata      = rddata_q;
  assign o_busy        = busy_q;
  assign o_end         = end_q;
  assign o_err         = err_q;
  assign o_bram_en     = en_q;
  assign o_bram_we     = we_q;
  assign o_bram_addr   = addr_q;
  assign o_bram_wrdata = wrdata_q;

endmodule

// File: tb/tb_bram_line_engine.sv
// Self-checking bench for bram_line_engine.
// A BRAM responder with RD_LAT cycles of read latency sits on the BRAM port.
// Expected behaviour comes from a word-array model of the BRAM contents and
// from per-cycle timing rules written as plain arithmetic on the trigger cycle.

module tb_bram_line_engine;

  localparam int LINE_W = 512;
  localparam int WORD_W = 32;
  localparam int ADDR_W = 15;
  localparam int RD_LAT = 2;
  localparam int NW     = LINE_W / WORD_W;
  localparam int CW     = 5;
  localparam int BS     = 4;
  localparam int DEPTH  = 1 << (ADDR_W - 2);

  logic              clk = 1'b0;
  logic              rst;
  logic              i_trigger;
  logic              i_mode;
  logic [ADDR_W-1:0] i_base_addr;
  logic [CW-1:0]     i_num_words;
  logic [LINE_W-1:0] i_wrdata;
  logic [LINE_W-1:0] o_rddata;
  logic              o_busy, o_end, o_err, o_bram_en;
  logic [BS-1:0]     o_bram_we;
  logic [ADDR_W-1:0] o_bram_addr;
  logic [WORD_W-1:0] o_bram_wrdata;
  logic [WORD_W-1:0] i_bram_rddata;

  always #5 clk = ~clk;

  bram_line_engine #(
    .LINE_W(LINE_W), .WORD_W(WORD_W), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT)
  ) dut (
    .S_AXI_ACLK   (clk),
    .S_AXI_ARESET (rst),
    .i_trigger    (i_trigger),
    .i_mode       (i_mode),
    .i_base_addr  (i_base_addr),
    .i_num_words  (i_num_words),
    .i_wrdata     (i_wrdata),
    .o_rddata     (o_rddata),
    .o_busy       (o_busy),
    .o_end        (o_end),
    .o_err        (o_err),
    .o_bram_en    (o_bram_en),
    .o_bram_we    (o_bram_we),
    .o_bram_addr  (o_bram_addr),
    .o_bram_wrdata(o_bram_wrdata),
    .i_bram_rddata(i_bram_rddata)
  );

  function automatic logic [WORD_W-1:0] preload(int i);
    return (32'(i) * 32'h0001_0203) ^ 32'h5EED_0000;
  endfunction

  // BRAM responder: synchronous writes, reads returned RD_LAT cycles later.
  logic [WORD_W-1:0] bram    [DEPTH];
  logic [WORD_W-1:0] rd_pipe [RD_LAT];

  initial begin
    for (int i = 0; i < DEPTH; i++) bram[i] <= preload(i);
    for (int i = 0; i < RD_LAT; i++) rd_pipe[i] <= '0;
    forever begin
      @(posedge clk);
      if (o_bram_en) begin
        if (o_bram_we == 4'hF) bram[o_bram_addr[ADDR_W-1:2]] <= o_bram_wrdata;
        else                   rd_pipe[0] <= bram[o_bram_addr[ADDR_W-1:2]];
      end
      for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
  end

  assign i_bram_rddata = rd_pipe[RD_LAT-1];

  // ---------------------------------------------------------------- checking
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [LINE_W-1:0] act,
                       input logic [LINE_W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic              en;
    logic [BS-1:0]     we;
    logic [ADDR_W-1:0] addr;
    logic              busy;
    logic              endp;
    logic              err;
  } obs_t;

  // ------------------------------------------------------------------ model
  logic [WORD_W-1:0] ref_mem [DEPTH];
  logic [LINE_W-1:0] ref_line;

  function automatic logic [ADDR_W-1:0] waddr(logic [ADDR_W-1:0] base, int k);
    logic [ADDR_W-1:0] b;
    b = base & 15'h7FFC;
    return ADDR_W'(int'(b) + k * BS);
  endfunction

  task automatic model_xfer(input logic mode, input logic [ADDR_W-1:0] base,
                            input logic [CW-1:0] n, input logic [LINE_W-1:0] line);
    logic [ADDR_W-1:0] a;
    if (n >= 1 && n <= NW) begin
      if (mode) begin
        for (int k = 0; k < int'(n); k++) begin
          a = waddr(base, k);
          ref_mem[a[ADDR_W-1:2]] = line[k*WORD_W +: WORD_W];
        end
      end else begin
        ref_line = '0;
        for (int k = 0; k < int'(n); k++) begin
          a = waddr(base, k);
          ref_line[k*WORD_W +: WORD_W] = ref_mem[a[ADDR_W-1:2]];
        end
      end
    end
  endtask

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] l;
    for (int w = 0; w < NW; w++) l[w*WORD_W +: WORD_W] = $urandom;
    return l;
  endfunction

  task automatic scramble_inputs();
    i_mode      = 1'($urandom);
    i_base_addr = ADDR_W'($urandom);
    i_num_words = CW'($urandom);
    i_wrdata    = rand_line();
  endtask

  // Applies one request at the current negedge (cycle T) and checks cycles
  // T+1 .. T+end_lat+1. A legal write trigger is held during the end cycle and
  // must be ignored.
  task automatic run_xfer(input string tag, input logic mode,
                          input logic [ADDR_W-1:0] base, input logic [CW-1:0] n,
                          input logic [LINE_W-1:0] line, input int end_lat,
                          input logic exp_err);
    obs_t act, exp;
    int   busy_last;
    model_xfer(mode, base, n, line);
    busy_last = mode ? int'(n) : int'(n) + RD_LAT;
    i_trigger   = 1'b1;
    i_mode      = mode;
    i_base_addr = base;
    i_num_words = n;
    i_wrdata    = line;
    @(posedge clk);
    #1;
    i_trigger = 1'b0;
    scramble_inputs();
    for (int k = 1; k <= end_lat + 1; k++) begin
      @(negedge clk);
      act.en   = o_bram_en;
      act.we   = o_bram_we;
      act.addr = o_bram_addr;
      act.busy = o_busy;
      act.endp = o_end;
      act.err  = o_err;
      exp.en   = !exp_err && k <= int'(n);
      exp.we   = (exp.en && mode) ? 4'hF : 4'h0;
      exp.addr = exp.en ? waddr(base, k - 1) : '0;
      exp.busy = !exp_err && k <= busy_last;
      exp.endp = (k == end_lat);
      exp.err  = exp_err && (k == end_lat);
      check($sformatf("%s bus k=%0d", tag, k), LINE_W'(act), LINE_W'(exp));
      if (exp.en && mode)
        check($sformatf("%s wrdata k=%0d", tag, k), LINE_W'(o_bram_wrdata),
              LINE_W'(line[(k-1)*WORD_W +: WORD_W]));
      if (k == end_lat) begin
        check($sformatf("%s rddata", tag), o_rddata, ref_line);
        i_trigger   = 1'b1;
        i_mode      = 1'b1;
        i_num_words = CW'(1);
      end
      if (k == end_lat + 1) i_trigger = 1'b0;
    end
  endtask

  typedef struct {
    logic              mode;
    logic [ADDR_W-1:0] base;
    logic [CW-1:0]     n;
    logic [WORD_W-1:0] seed;
    int                end_lat;
    logic              exp_err;
  } vec_t;

  initial begin
    vec_t              tbl [10];
    logic [LINE_W-1:0] line;
    logic              mode;
    logic [CW-1:0]     n;
    logic              illegal;
    int                lat;
    int                end_cnt;
    obs_t              act;

    tbl[0] = '{1'b1, 15'h0100, 5'd16, 32'hA000_0000, 17, 1'b0};
    tbl[1] = '{1'b0, 15'h0100, 5'd16, 32'h0,         19, 1'b0};
    tbl[2] = '{1'b0, 15'h0108, 5'd3,  32'h0,          6, 1'b0};
    tbl[3] = '{1'b1, 15'h7FF8, 5'd4,  32'hB000_0000,  5, 1'b0};
    tbl[4] = '{1'b0, 15'h7FF8, 5'd4,  32'h0,          7, 1'b0};
    tbl[5] = '{1'b1, 15'h0100, 5'd0,  32'hC000_0000,  1, 1'b1};
    tbl[6] = '{1'b0, 15'h0100, 5'd17, 32'h0,          1, 1'b1};
    tbl[7] = '{1'b1, 15'h0203, 5'd1,  32'hD000_0000,  2, 1'b0};
    tbl[8] = '{1'b0, 15'h0202, 5'd2,  32'h0,          5, 1'b0};
    tbl[9] = '{1'b1, 15'h7FC0, 5'd16, 32'hE000_0000, 17, 1'b0};

    rst         = 1'b1;
    i_trigger   = 1'b0;
    i_mode      = 1'b0;
    i_base_addr = '0;
    i_num_words = '0;
    i_wrdata    = '0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = preload(i);
    ref_line = '0;

    repeat (3) @(negedge clk);
    check("reset outputs",
          LINE_W'({o_bram_en, o_bram_we, o_bram_addr, o_bram_wrdata, o_busy, o_end, o_err}),
          '0);
    check("reset rddata", o_rddata, '0);
    rst = 1'b0;
    @(negedge clk);

    // Table-driven directed transfers.
    for (int v = 0; v < 10; v++) begin
      for (int w = 0; w < NW; w++) line[w*WORD_W +: WORD_W] = tbl[v].seed + 32'(w);
      run_xfer($sformatf("tbl%0d", v), tbl[v].mode, tbl[v].base, tbl[v].n, line,
               tbl[v].end_lat, tbl[v].exp_err);
    end

    // Random transfers checked against the model.
    for (int r = 0; r < 40; r++) begin
      mode    = 1'($urandom);
      n       = CW'($urandom_range(0, NW + 1));
      illegal = (n == 0) || (n > NW);
      lat     = illegal ? 1 : (mode ? int'(n) + 1 : int'(n) + RD_LAT + 1);
      run_xfer($sformatf("rnd%0d", r), mode, ADDR_W'($urandom), n, rand_line(),
               lat, illegal);
    end

    // Reset during the 5th issue cycle of a 16-word read.
    model_xfer(1'b0, 15'h0100, 5'd16, '0);
    i_trigger   = 1'b1;
    i_mode      = 1'b0;
    i_base_addr = 15'h0100;
    i_num_words = 5'd16;
    @(posedge clk);
    #1;
    i_trigger = 1'b0;
    scramble_inputs();
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      act.en   = o_bram_en;
      act.we   = o_bram_we;
      act.addr = o_bram_addr;
      act.busy = o_busy;
      act.endp = o_end;
      act.err  = o_err;
      check($sformatf("abort issue k=%0d", k), LINE_W'(act),
            LINE_W'({1'b1, 4'h0, waddr(15'h0100, k - 1), 1'b1, 1'b0, 1'b0}));
    end
    rst = 1'b1;
    ref_line = '0;
    @(negedge clk);
    check("abort outputs",
          LINE_W'({o_bram_en, o_bram_we, o_bram_addr, o_bram_wrdata, o_busy, o_end, o_err}),
          '0);
    check("abort rddata", o_rddata, '0);
    end_cnt = 0;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (o_end || o_busy || o_bram_en) end_cnt++;
    end
    check("abort quiet", LINE_W'(end_cnt), '0);
    line = rand_line();
    run_xfer("post-reset read", 1'b0, 15'h0100, 5'd16, line, 19, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
